// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one sequential divider among NREQ requesters,
// sequencing start/busy/completion and returning a registered result with a done pulse.
module div_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 10,
  parameter int TMO  = 8
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] a_in,
  input  logic [NREQ*DW-1:0] b_in,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      res_q,
  output logic               res_dvz,
  output logic               res_ovf,
  output logic               res_err,
  output logic               div_start,
  output logic [DW-1:0]      div_a,
  output logic [DW-1:0]      div_b,
  input  logic               div_busy,
  input  logic               div_valid,
  input  logic               div_dvz,
  input  logic               div_ovf,
  input  logic [DW-1:0]      div_q
);

  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_REL,
    S_RUN,
    S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            start_q, start_d;
  logic [DW-1:0]   result_q, result_d;
  logic            dvz_q, dvz_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;

  logic            win_found;
  logic [SW-1:0]   win_idx;
  int              cand;

  logic            fin;
  logic [DW-1:0]   f_q;
  logic            f_dvz, f_ovf, f_err;

  // Scan downward so the last hit is the one closest to the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = SW'(cand);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    tmo_d    = tmo_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    start_d  = 1'b0;
    result_d = result_q;
    dvz_d    = dvz_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    fin      = 1'b0;
    f_q      = '0;
    f_dvz    = 1'b0;
    f_ovf    = 1'b0;
    f_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          sel_d   = win_idx;
          gnt_d   = NREQ'(1) << win_idx;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_REL;
      end
      S_REL: begin
        if (div_busy) begin
          state_d = S_RUN;
        end else if (tmo_q == CW'(TMO)) begin
          fin   = 1'b1;
          f_err = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RUN: begin
        if (div_dvz) begin
          fin   = 1'b1;
          f_dvz = 1'b1;
        end else if (div_ovf) begin
          fin   = 1'b1;
          f_ovf = 1'b1;
        end else if (div_valid) begin
          fin = 1'b1;
          f_q = div_q;
        end
      end
      S_FIN: begin
        ptr_d   = (sel_q == SW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // All result fields change together on entry to FIN, alongside done and gnt release.
    if (fin) begin
      state_d       = S_FIN;
      gnt_d         = '0;
      done_d[sel_q] = 1'b1;
      result_d      = f_q;
      dvz_d         = f_dvz;
      ovf_d         = f_ovf;
      err_d         = f_err;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      tmo_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
      result_q <= '0;
      dvz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      tmo_q    <= tmo_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      start_q  <= start_d;
      result_q <= result_d;
      dvz_q    <= dvz_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    div_a = '0;
    div_b = '0;
    if (|gnt_q) begin
      div_a = a_in[int'(sel_q)*DW +: DW];
      div_b = b_in[int'(sel_q)*DW +: DW];
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign div_start = start_q;
  assign res_q     = result_q;
  assign res_dvz   = dvz_q;
  assign res_ovf   = ovf_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider model, result scoreboard, vector table
// and hand-written sequences for timeout, contention and mid-job reset.
`timescale 1ns/1ps
module tb_div_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 10;
  localparam int TMO  = 8;

  typedef enum int {M_NORM, M_OVF, M_BOTH, M_NOBUSY} mode_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] q;
    logic          dvz;
    logic          ovf;
    logic          err;
  } exp_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    mode_t         mode;
    logic [DW-1:0] q;
    logic          dvz;
    logic          ovf;
    logic          err;
  } vec_t;

  logic               clk;
  logic               sclr;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] a_in;
  logic [NREQ*DW-1:0] b_in;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      res_q;
  logic               res_dvz;
  logic               res_ovf;
  logic               res_err;
  logic               div_start;
  logic [DW-1:0]      div_a;
  logic [DW-1:0]      div_b;
  logic               div_busy;
  logic               div_valid;
  logic               div_dvz;
  logic               div_ovf;
  logic [DW-1:0]      div_q;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  mode_t mode  = M_NORM;
  int    lat_cfg = 3;
  exp_t  sb[$];
  exp_t  mon_e;
  vec_t  vecs[7];

  div_arbiter #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
    .clk       (clk),
    .sclr      (sclr),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .done      (done),
    .res_q     (res_q),
    .res_dvz   (res_dvz),
    .res_ovf   (res_ovf),
    .res_err   (res_err),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_busy  (div_busy),
    .div_valid (div_valid),
    .div_dvz   (div_dvz),
    .div_ovf   (div_ovf),
    .div_q     (div_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divider model: begins when start falls, stays busy lat_cfg cycles, then pulses a result.
  initial begin
    logic          start_seen;
    int            lat;
    logic [DW-1:0] op_a, op_b;
    start_seen = 1'b0;
    lat        = 0;
    op_a       = '0;
    op_b       = '0;
    div_busy   = 1'b0;
    div_valid  = 1'b0;
    div_dvz    = 1'b0;
    div_ovf    = 1'b0;
    div_q      = '0;
    forever begin
      @(negedge clk or posedge sclr);
      if (sclr) begin
        start_seen = 1'b0;
        div_busy   = 1'b0;
        div_valid  = 1'b0;
        div_dvz    = 1'b0;
        div_ovf    = 1'b0;
        div_q      = '0;
      end else begin
        div_valid = 1'b0;
        div_dvz   = 1'b0;
        div_ovf   = 1'b0;
        if (div_start) begin
          start_seen = 1'b1;
        end else if (start_seen) begin
          start_seen = 1'b0;
          if (mode != M_NOBUSY) begin
            div_busy = 1'b1;
            lat      = lat_cfg;
            op_a     = div_a;
            op_b     = div_b;
          end
        end else if (div_busy) begin
          if (lat > 1) begin
            lat--;
          end else begin
            div_busy  = 1'b0;
            div_dvz   = (op_b == '0);
            div_ovf   = (mode == M_OVF) || (mode == M_BOTH);
            div_valid = (op_b != '0) && ((mode == M_NORM) || (mode == M_BOTH));
            div_q     = (op_b != '0) ? op_a / op_b : '1;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every done pops one expected completion.
  initial forever begin
    @(negedge clk);
    if (!sclr) begin
      if (gnt != '0) check("gnt_onehot", $countones(gnt), 1);
      if (done != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 0);
        end else begin
          mon_e = sb.pop_front();
          check("done_idx", 32'(done), 32'(1) << mon_e.idx);
          check("gnt_cleared_at_done", 32'(gnt), 0);
          check("res_q", 32'(res_q), 32'(mon_e.q));
          check("res_dvz", 32'(res_dvz), 32'(mon_e.dvz));
          check("res_ovf", 32'(res_ovf), 32'(mon_e.ovf));
          check("res_err", 32'(res_err), 32'(mon_e.err));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    a_in[i*DW +: DW] = a;
    b_in[i*DW +: DW] = b;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < budget);
    if (done == '0) check("done_wait", 32'(done != '0), 1);
  endtask

  initial begin
    int   n;
    int   t_start;
    int   t_valid;
    exp_t e;

    vecs[0] = '{idx: 0, a: 20,   b: 4, mode: M_NORM, q: 5,   dvz: 0, ovf: 0, err: 0};
    vecs[1] = '{idx: 1, a: 33,   b: 0, mode: M_NORM, q: 0,   dvz: 1, ovf: 0, err: 0};
    vecs[2] = '{idx: 0, a: 1023, b: 1, mode: M_OVF,  q: 0,   dvz: 0, ovf: 1, err: 0};
    vecs[3] = '{idx: 1, a: 100,  b: 7, mode: M_BOTH, q: 0,   dvz: 0, ovf: 1, err: 0};
    vecs[4] = '{idx: 0, a: 7,    b: 0, mode: M_OVF,  q: 0,   dvz: 1, ovf: 0, err: 0};
    vecs[5] = '{idx: 1, a: 1023, b: 2, mode: M_NORM, q: 511, dvz: 0, ovf: 0, err: 0};
    vecs[6] = '{idx: 0, a: 3,    b: 5, mode: M_NORM, q: 0,   dvz: 0, ovf: 0, err: 0};

    sclr = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt_done", {gnt, done}, 0);
    check("rst_res", {res_q, res_dvz, res_ovf, res_err}, 0);
    check("rst_div_io", {div_start, div_a, div_b}, 0);
    sclr = 1'b0;
    @(negedge clk);

    // Single job with timing of grant, start pulse and done after valid.
    set_ops(0, 20, 4);
    e = '{idx: 0, q: 5, dvz: 0, ovf: 0, err: 0};
    sb.push_back(e);
    req = 2'b01;
    @(negedge clk);
    check("sj_gnt", 32'(gnt), 1);
    check("sj_start", 32'(div_start), 1);
    check("sj_div_a", 32'(div_a), 20);
    check("sj_div_b", 32'(div_b), 4);
    @(negedge clk);
    check("sj_start_one_cycle", 32'(div_start), 0);
    t_valid = -100;
    n = 0;
    while (done == '0 && n < 60) begin
      @(negedge clk);
      n++;
      if (div_valid) t_valid = cyc;
    end
    check("sj_done_seen", 32'(done != '0), 1);
    check("sj_done_after_valid", cyc - t_valid, 1);
    req = '0;
    @(negedge clk);

    // Vector table.
    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      set_ops(vecs[i].idx, vecs[i].a, vecs[i].b);
      e = '{idx: vecs[i].idx, q: vecs[i].q, dvz: vecs[i].dvz, ovf: vecs[i].ovf, err: vecs[i].err};
      sb.push_back(e);
      req = NREQ'(1) << vecs[i].idx;
      wait_done(60);
      req  = '0;
      mode = M_NORM;
      @(negedge clk);
    end

    // Timeout: divider never raises busy.
    mode = M_NOBUSY;
    set_ops(1, 9, 3);
    e = '{idx: 1, q: 0, dvz: 0, ovf: 0, err: 1};
    sb.push_back(e);
    req = 2'b10;
    t_start = -100;
    n = 0;
    while (done == '0 && n < 60) begin
      @(negedge clk);
      n++;
      if (div_start) t_start = cyc;
    end
    check("tmo_done_seen", 32'(done != '0), 1);
    check("tmo_latency", cyc - t_start, TMO + 2);
    req  = '0;
    mode = M_NORM;
    @(negedge clk);
    check("tmo_gnt_released", 32'(gnt), 0);
    set_ops(0, 40, 8);
    e = '{idx: 0, q: 5, dvz: 0, ovf: 0, err: 0};
    sb.push_back(e);
    req = 2'b01;
    @(negedge clk);
    check("tmo_back_to_idle", 32'(gnt), 1);
    wait_done(60);
    req = '0;
    @(negedge clk);

    // Contention from reset: both requests held, grants alternate 0,1,0.
    #2 sclr = 1'b1;
    set_ops(0, 20, 4);
    set_ops(1, 30, 5);
    req = 2'b11;
    sb.delete();
    @(negedge clk);
    #2 sclr = 1'b0;
    e = '{idx: 0, q: 5, dvz: 0, ovf: 0, err: 0};
    sb.push_back(e);
    e = '{idx: 1, q: 6, dvz: 0, ovf: 0, err: 0};
    sb.push_back(e);
    e = '{idx: 0, q: 5, dvz: 0, ovf: 0, err: 0};
    sb.push_back(e);
    repeat (3) wait_done(60);
    req = '0;
    @(negedge clk);
    check("cont_all_done", sb.size(), 0);

    // Reset in the middle of RUN aborts the job without a done.
    lat_cfg = 8;
    set_ops(1, 50, 5);
    req = 2'b10;
    n = 0;
    while (!div_busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("mr_busy_seen", 32'(div_busy), 1);
    @(negedge clk);
    check("mr_gnt_in_run", 32'(gnt), 2);
    #2 sclr = 1'b1;
    #1;
    check("mr_gnt_done", {gnt, done}, 0);
    check("mr_res", {res_q, res_dvz, res_ovf, res_err}, 0);
    check("mr_start", 32'(div_start), 0);
    @(negedge clk);
    lat_cfg = 3;
    #2 sclr = 1'b0;
    e = '{idx: 1, q: 10, dvz: 0, ovf: 0, err: 0};
    sb.push_back(e);
    @(negedge clk);
    check("mr_regrant", 32'(gnt), 2);
    wait_done(60);
    req = '0;

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
